// File: rtl/rv_mdu_if.sv
// Request/response bundle between the core control path and the multiply/divide unit.
interface rv_mdu_if #(
  parameter int DPWIDTH = 32
);
  logic               start;
  logic               flush;
  logic [2:0]         funct3;
  logic [DPWIDTH-1:0] op_a;
  logic [DPWIDTH-1:0] op_b;
  logic               busy;
  logic               done;
  logic [DPWIDTH-1:0] result;

  modport master (
    output start, flush, funct3, op_a, op_b,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, funct3, op_a, op_b,
    output busy, done, result
  );
endinterface

// File: rtl/rv_mdu.sv
// Iterative RV32M multiply/divide unit: one bit per cycle shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up and the architected
// divide-by-zero / overflow results applied in a final FIX cycle.
module rv_mdu #(
  parameter int DPWIDTH = 32,
  localparam int CNTW = $clog2(DPWIDTH) + 1
) (
  input logic     clk,
  input logic     rst,
  rv_mdu_if.slave bus
);
  localparam logic [DPWIDTH-1:0] MIN = {1'b1, {(DPWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state, state_next;
  logic [CNTW-1:0]      cnt_reg;
  logic [DPWIDTH-1:0]   a_reg, b_reg;       // raw captured operands
  logic [2:0]           f3_reg;
  logic [DPWIDTH-1:0]   addend_reg;         // multiplicand (mul) or divisor (div) magnitude
  logic [DPWIDTH-1:0]   hi_reg, lo_reg;     // product halves, or remainder / quotient
  logic [DPWIDTH-1:0]   result_reg;
  logic                 done_reg;

  logic [DPWIDTH-1:0]   hi_next, lo_next, fix_value;
  logic [DPWIDTH:0]     sum, shifted;
  logic [DPWIDTH-1:0]   diff;
  logic                 in_neg_a, in_neg_b, in_special, launch;
  logic [DPWIDTH-1:0]   in_mag_a, in_mag_b;
  logic                 fix_neg_a, fix_neg_b, div0, ovf;
  logic [2*DPWIDTH-1:0] prod, prod_fix;
  logic [DPWIDTH-1:0]   quo_fix, rem_fix;

  // MULH, MULHSU, DIV, REM treat rs1 as signed.
  function automatic logic a_signed(input logic [2:0] f);
    return (f == 3'b001) || (f == 3'b010) || (f == 3'b100) || (f == 3'b110);
  endfunction

  // MULH, DIV, REM treat rs2 as signed.
  function automatic logic b_signed(input logic [2:0] f);
    return (f == 3'b001) || (f == 3'b100) || (f == 3'b110);
  endfunction

  assign in_neg_a   = a_signed(bus.funct3) & bus.op_a[DPWIDTH-1];
  assign in_neg_b   = b_signed(bus.funct3) & bus.op_b[DPWIDTH-1];
  assign in_mag_a   = in_neg_a ? -bus.op_a : bus.op_a;
  assign in_mag_b   = in_neg_b ? -bus.op_b : bus.op_b;
  assign in_special = bus.funct3[2] &&
                      (bus.op_b == '0 ||
                       (!bus.funct3[0] && bus.op_a == MIN && bus.op_b == '1));
  assign launch     = (state == IDLE) && bus.start && !bus.flush;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode; flush forces IDLE from anywhere and drops a coincident start.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = in_special ? FIX : CALC;
      CALC:    if (cnt_reg == CNTW'(1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  // One iteration: shift-add step for multiply, restoring step for divide.
  always_comb begin
    sum     = '0;
    shifted = '0;
    diff    = '0;
    hi_next = hi_reg;
    lo_next = lo_reg;
    if (!f3_reg[2]) begin
      sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, addend_reg} : '0);
      hi_next = sum[DPWIDTH:1];
      lo_next = {sum[0], lo_reg[DPWIDTH-1:1]};
    end else begin
      shifted = {hi_reg, lo_reg[DPWIDTH-1]};
      diff    = shifted[DPWIDTH-1:0] - addend_reg;
      if (shifted >= {1'b0, addend_reg}) begin
        hi_next = diff;
        lo_next = {lo_reg[DPWIDTH-2:0], 1'b1};
      end else begin
        hi_next = shifted[DPWIDTH-1:0];
        lo_next = {lo_reg[DPWIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign correction and output selection, including the architected special results.
  always_comb begin
    fix_neg_a = a_signed(f3_reg) & a_reg[DPWIDTH-1];
    fix_neg_b = b_signed(f3_reg) & b_reg[DPWIDTH-1];
    prod      = {hi_reg, lo_reg};
    prod_fix  = (fix_neg_a ^ fix_neg_b) ? -prod : prod;
    quo_fix   = (fix_neg_a ^ fix_neg_b) ? -lo_reg : lo_reg;
    rem_fix   = fix_neg_a ? -hi_reg : hi_reg;
    div0      = (b_reg == '0);
    ovf       = !f3_reg[0] && (a_reg == MIN) && (b_reg == '1);
    fix_value = '0;
    if (!f3_reg[2])
      fix_value = (f3_reg[1:0] == 2'b00) ? prod_fix[DPWIDTH-1:0] : prod_fix[2*DPWIDTH-1:DPWIDTH];
    else if (div0)
      fix_value = f3_reg[1] ? a_reg : '1;
    else if (ovf)
      fix_value = f3_reg[1] ? '0 : MIN;
    else
      fix_value = f3_reg[1] ? rem_fix : quo_fix;
  end

  // Operand capture, iteration registers, and registered result/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      f3_reg     <= '0;
      addend_reg <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= (state == FIX) && !bus.flush;
      if (launch) begin
        a_reg      <= bus.op_a;
        b_reg      <= bus.op_b;
        f3_reg     <= bus.funct3;
        cnt_reg    <= in_special ? '0 : CNTW'(DPWIDTH);
        hi_reg     <= '0;
        lo_reg     <= bus.funct3[2] ? in_mag_a : in_mag_b;
        addend_reg <= bus.funct3[2] ? in_mag_b : in_mag_a;
      end else if (state == CALC && !bus.flush) begin
        cnt_reg <= cnt_reg - CNTW'(1);
        hi_reg  <= hi_next;
        lo_reg  <= lo_next;
      end
      if (state == FIX && !bus.flush) result_reg <= fix_value;
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_reg;
  assign bus.result = result_reg;
endmodule

// File: tb/tb_rv_mdu.sv
// Scoreboard bench for rv_mdu at DPWIDTH=32: expected results are queued at issue
// and compared when done pulses; latency, busy window and control cases checked inline.
module tb_rv_mdu;
  localparam int W = 32;
  localparam logic [W-1:0] MIN = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv_mdu_if #(.DPWIDTH(W)) m();
  rv_mdu #(.DPWIDTH(W)) dut (.clk(clk), .rst(rst), .bus(m));

  int           n_vec = 0;
  int           n_err = 0;
  int           done_seen = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_res = '0;
  logic [W-1:0] mon_exp;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit special(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    return f[2] && (b == '0 || (!f[0] && a == MIN && b == '1));
  endfunction

  // Architectural reference for all eight RV32M operations.
  function automatic logic [W-1:0] model(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] xa, xb, p;
    logic signed [W-1:0]   sa, sb, q, rm;
    logic [W-1:0]          r;
    xa = (f == 3'b001 || f == 3'b010) ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    xb = (f == 3'b001) ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    p  = xa * xb;
    sa = a;
    sb = b;
    q  = '0;
    rm = '0;
    if (b != '0 && !(a == MIN && b == '1)) begin
      q  = sa / sb;
      rm = sa % sb;
    end
    case (f)
      3'b000:  r = p[W-1:0];
      3'b001, 3'b010, 3'b011: r = p[2*W-1:W];
      3'b100:  r = (b == '0) ? '1 : (a == MIN && b == '1) ? MIN : q;
      3'b101:  r = (b == '0) ? '1 : a / b;
      3'b110:  r = (b == '0) ? a : (a == MIN && b == '1) ? '0 : rm;
      default: r = (b == '0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Result monitor: pop the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (!rst && m.done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_done", W'(m.done), '0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("result", m.result, mon_exp);
        last_res = mon_exp;
        $display("done: result=%h expected=%h", m.result, mon_exp);
      end
    end
  end

  // Issue one operation from a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
    int k;
    int lat;
    bit busy_ok;
    lat = special(f, a, b) ? 2 : W + 2;
    m.start  = 1'b1;
    m.funct3 = f;
    m.op_a   = a;
    m.op_b   = b;
    exp_q.push_back(model(f, a, b));
    $display("issue: f3=%0d a=%h b=%h noise=%0d", f, a, b, noise);
    busy_ok = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) m.start = 1'b0;
      if (noise && k == 5) begin
        m.start  = 1'b1;
        m.funct3 = 3'b101;
        m.op_a   = $urandom;
        m.op_b   = $urandom;
      end
      if (noise && k == 6) m.start = 1'b0;
      if (!m.done && !m.busy) busy_ok = 1'b0;
    end while (!m.done && k < W + 10);
    check_eq("latency", W'(k), W'(lat));
    check_eq("busy_window", W'(busy_ok), W'(1));
    check_eq("busy_at_done", W'(m.busy), '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0]   f;
    logic [W-1:0] a, b, held;
    int           d0;
    bit           nz;

    rst = 1'b1;
    m.start = 1'b0; m.flush = 1'b0; m.funct3 = '0; m.op_a = '0; m.op_b = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_busy",   W'(m.busy), '0);
    check_eq("reset_done",   W'(m.done), '0);
    check_eq("reset_result", m.result,   '0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors, issued back-to-back (each start lands in the previous done cycle).
    run_op(3'b000, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op(3'b001, MIN, MIN, 1'b0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'b101, 32'h1234_5678, 32'd0, 1'b0);
    run_op(3'b111, 32'h1234_5678, 32'd0, 1'b0);
    run_op(3'b100, MIN, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b110, MIN, 32'hFFFF_FFFF, 1'b0);
    // Start pulses while busy must not disturb the operation in flight.
    run_op(3'b101, 32'd1000, 32'd7, 1'b1);
    run_op(3'b001, 32'h8765_4321, 32'h1357_9BDF, 1'b1);

    // Flush in cycle 10 of a DIVU.
    @(negedge clk);
    held = last_res;
    d0 = done_seen;
    m.start = 1'b1; m.funct3 = 3'b101; m.op_a = 32'd999; m.op_b = 32'd3;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) m.start = 1'b0;
    end
    m.flush = 1'b1;
    @(negedge clk);
    m.flush = 1'b0;
    check_eq("flush_busy", W'(m.busy), '0);
    repeat (40) @(negedge clk);
    check_eq("flush_no_done", W'(done_seen - d0), '0);
    check_eq("flush_result", m.result, held);

    // Start coincident with flush is dropped.
    d0 = done_seen;
    m.start = 1'b1; m.flush = 1'b1; m.funct3 = 3'b000; m.op_a = 32'd5; m.op_b = 32'd5;
    @(negedge clk);
    m.start = 1'b0; m.flush = 1'b0;
    check_eq("startflush_busy", W'(m.busy), '0);
    repeat (40) @(negedge clk);
    check_eq("startflush_no_done", W'(done_seen - d0), '0);
    check_eq("startflush_result", m.result, held);

    // Randomised mix with edge operands.
    for (int i = 0; i < 16; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) b = '0;
      if (i % 4 == 2) begin a = MIN; b = '1; end
      if (i % 4 == 3) b = 32'($urandom_range(1, 9));
      nz = (i % 3 == 0) && !special(f, a, b);
      run_op(f, a, b, nz);
    end

    // Reset in cycle 5 of a MUL.
    @(negedge clk);
    m.start = 1'b1; m.funct3 = 3'b000; m.op_a = 32'd11; m.op_b = 32'd13;
    exp_q.push_back(model(3'b000, 32'd11, 32'd13));
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) m.start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check_eq("midrst_busy",   W'(m.busy), '0);
    check_eq("midrst_done",   W'(m.done), '0);
    check_eq("midrst_result", m.result,   '0);
    exp_q.delete();
    last_res = '0;
    d0 = done_seen;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("midrst_no_done", W'(done_seen - d0), '0);

    // Recovery after reset.
    run_op(3'b000, 32'd6, 32'd7, 1'b0);
    @(negedge clk);
    check_eq("queue_drained", W'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
